dmem_arbiter: RTL

Two-port arbiter and access sequencer in front of the 64-word data memory. It shares the single memory port between port 0 (core load/store path) and port 1 (debug/loader path) using round-robin arbitration and a req/ack handshake. It also turns byte-enabled partial stores into a read-modify-write sequence, because the memory array supports only full-word writes. It sits between the requesters and the memory's `MemRead`/`MemWrite`/`Address`/`writeData`/`readData` pins.

---
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter for the 64-word data memory; partial stores
// become a read-modify-write because the array only accepts full-word writes.
module dmem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RMW_WR, S_DONE} state_t;

  state_t      r_state;
  logic        r_grant;
  logic        r_last_grant;
  logic        r_lat_we;
  logic [3:0]  r_lat_be;
  logic [31:0] r_lat_wdata;
  logic [31:0] r_merged;
  logic        r_ack0;
  logic        r_ack1;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic        w_sel;
  logic        w_sel_we;
  logic [3:0]  w_sel_be;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_sel_full;
  logic        w_sel_partial;
  logic        w_lat_partial;
  logic [31:0] w_be_mask;
  logic [31:0] w_merged;
  logic        w_unused_addr_lsb;

  // A tie goes to the port that was not served last.
  assign w_sel       = (m0_req && m1_req) ? ~r_last_grant : m1_req;
  assign w_sel_we    = w_sel ? m1_we    : m0_we;
  assign w_sel_be    = w_sel ? m1_be    : m0_be;
  assign w_sel_addr  = w_sel ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_sel ? m1_wdata : m0_wdata;

  assign w_sel_full    = w_sel_we && (w_sel_be == 4'hF);
  assign w_sel_partial = w_sel_we && (w_sel_be != 4'h0) && (w_sel_be != 4'hF);
  assign w_lat_partial = r_lat_we && (r_lat_be != 4'h0) && (r_lat_be != 4'hF);

  assign w_be_mask = {{8{r_lat_be[3]}}, {8{r_lat_be[2]}}, {8{r_lat_be[1]}}, {8{r_lat_be[0]}}};
  assign w_merged  = (r_lat_wdata & w_be_mask) | (mem_rdata & ~w_be_mask);

  assign w_unused_addr_lsb = ^{w_sel_addr[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_lat_we     <= 1'b0;
      r_lat_be     <= 4'h0;
      r_lat_wdata  <= 32'h0;
      r_merged     <= 32'h0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_rdata0     <= 32'h0;
      r_rdata1     <= 32'h0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (m0_req || m1_req) begin
            r_grant     <= w_sel;
            r_lat_we    <= w_sel_we;
            r_lat_be    <= w_sel_be;
            r_lat_wdata <= w_sel_wdata;
            r_mem_read  <= !w_sel_we || w_sel_partial;
            r_mem_write <= w_sel_full;
            r_mem_addr  <= {w_sel_addr[31:2], 2'b00};
            r_mem_wdata <= w_sel_full ? w_sel_wdata : 32'h0;
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!r_lat_we) begin
            if (r_grant) r_rdata1 <= mem_rdata;
            else         r_rdata0 <= mem_rdata;
          end
          if (w_lat_partial) begin
            r_merged    <= w_merged;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b1;
            r_mem_wdata <= w_merged;
            r_state     <= S_RMW_WR;
          end else begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_ack0      <= !r_grant;
            r_ack1      <= r_grant;
            r_state     <= S_DONE;
          end
        end
        S_RMW_WR: begin
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_mem_addr  <= 32'h0;
          r_mem_wdata <= 32'h0;
          r_ack0      <= !r_grant;
          r_ack1      <= r_grant;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          r_ack0       <= 1'b0;
          r_ack1       <= 1'b0;
          r_last_grant <= r_grant;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m0_ack    = r_ack0;
  assign m1_ack    = r_ack1;
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
